// File: rtl/acquisition_sequencer.sv
// Light-modulated photon-counting sequencer: alternating on/off half periods,
// blanked settle time, latched on/off totals. Optional macro ACQ_BLANK_COUNT_EN.
module acquisition_sequencer #(
  parameter int HALF_PERIOD  = 250000,
  parameter int BLANK_CYCLES = 5000,
  parameter int PERIODS      = 300,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                          clock_50_mhz,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          pulse_in,
  output logic                          light_source_pin,
  output logic                          busy,
  output logic [1:0]                    state,
  output logic [COUNT_WIDTH-1:0]        add_count,
  output logic [COUNT_WIDTH-1:0]        subtract_count,
  output logic signed [COUNT_WIDTH:0]   difference,
  output logic [COUNT_WIDTH-1:0]        blank_count,
  output logic                          result_valid
);

  localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int HW = (2 * PERIODS > 1) ? $clog2(2 * PERIODS) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_SETTLE = TW'(BLANK_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(2 * PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_LATCH  = 2'd3
  } state_t;

  // Every half period opens in SETTLE unless there is nothing to blank.
  localparam state_t S_FIRST = (BLANK_CYCLES > 0) ? S_SETTLE : S_COUNT;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v,
    input logic                   en
  );
    return (en && (v != '1)) ? v + COUNT_WIDTH'(1) : v;
  endfunction

  state_t                   r_state;
  logic [TW-1:0]            r_tmr;
  logic [HW-1:0]            r_half;
  logic                     r_light;
  logic [COUNT_WIDTH-1:0]   r_add_acc, r_sub_acc;
  logic [COUNT_WIDTH-1:0]   r_add_count, r_sub_count;
  logic signed [COUNT_WIDTH:0] r_diff;
  logic                     r_valid;

  logic                     w_cnt;
  logic                     w_t_last, w_h_last, w_settle_done;
  logic [COUNT_WIDTH-1:0]   w_add_nxt, w_sub_nxt;

  assign w_t_last      = (r_tmr == T_LAST);
  assign w_h_last      = (r_half == H_LAST);
  assign w_settle_done = (r_tmr == T_SETTLE);
  assign w_cnt         = (r_state == S_COUNT) && pulse_in;
  // Light level doubles as the phase flag; it is only low in a window while off.
  assign w_add_nxt     = sat_inc(r_add_acc, w_cnt && r_light);
  assign w_sub_nxt     = sat_inc(r_sub_acc, w_cnt && !r_light);

  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_half      <= '0;
      r_light     <= 1'b0;
      r_add_acc   <= '0;
      r_sub_acc   <= '0;
      r_add_count <= '0;
      r_sub_count <= '0;
      r_diff      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FIRST;
            r_light <= 1'b1;
            r_tmr   <= '0;
            r_half  <= '0;
          end
        end
        S_SETTLE, S_COUNT: begin
          if (!run) begin
            r_state   <= S_IDLE;
            r_light   <= 1'b0;
            r_tmr     <= '0;
            r_half    <= '0;
            r_add_acc <= '0;
            r_sub_acc <= '0;
          end else begin
            r_add_acc <= w_add_nxt;
            r_sub_acc <= w_sub_nxt;
            if (w_t_last) begin
              r_tmr <= '0;
              if (w_h_last) begin
                r_state <= S_LATCH;
                r_light <= 1'b0;
                r_half  <= '0;
              end else begin
                r_state <= S_FIRST;
                r_light <= !r_light;
                r_half  <= r_half + HW'(1);
              end
            end else begin
              r_tmr <= r_tmr + TW'(1);
              if (r_state == S_SETTLE && w_settle_done)
                r_state <= S_COUNT;
            end
          end
        end
        S_LATCH: begin
          r_add_count <= r_add_acc;
          r_sub_count <= r_sub_acc;
          r_diff      <= $signed({1'b0, r_add_acc}) - $signed({1'b0, r_sub_acc});
          r_add_acc   <= '0;
          r_sub_acc   <= '0;
          r_valid     <= 1'b1;
          r_tmr       <= '0;
          r_half      <= '0;
          if (run) begin
            r_state <= S_FIRST;
            r_light <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_light <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_light <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACQ_BLANK_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_blk_acc, r_blk_count;
  logic                   w_blk_hit;
  logic [COUNT_WIDTH-1:0] w_blk_nxt;

  assign w_blk_hit = pulse_in && (r_state == S_SETTLE || r_state == S_LATCH);
  assign w_blk_nxt = sat_inc(r_blk_acc, w_blk_hit);

  // A pulse in the LATCH cycle itself still lands in the latched total.
  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      r_blk_acc   <= '0;
      r_blk_count <= '0;
    end else if (r_state == S_LATCH) begin
      r_blk_count <= w_blk_nxt;
      r_blk_acc   <= '0;
    end else if ((r_state == S_SETTLE || r_state == S_COUNT) && !run) begin
      r_blk_acc   <= '0;
    end else begin
      r_blk_acc   <= w_blk_nxt;
    end
  end

  assign blank_count = r_blk_count;
`else
  assign blank_count = '0;
`endif

  assign state            = r_state;
  assign busy             = (r_state != S_IDLE);
  assign light_source_pin = r_light;
  assign add_count        = r_add_count;
  assign subtract_count   = r_sub_count;
  assign difference       = r_diff;
  assign result_valid     = r_valid;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Randomised + directed bench for acquisition_sequencer against a window-position model.
module tb_acquisition_sequencer;
  localparam int H = 8, B = 2, P = 2, CW = 32;
  localparam int WIN = 2 * P * H;
`ifdef ACQ_BLANK_COUNT_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, pulse, run_b, pulse_b;
  logic light, busy, rv;
  logic [1:0] st;
  logic [CW-1:0] addc, subc, blkc;
  logic signed [CW:0] diff;
  logic light_b, busy_b, rv_b;
  logic [1:0] st_b;
  logic [3:0] add_b, sub_b, blk_b;
  logic signed [4:0] diff_b;

  acquisition_sequencer #(.HALF_PERIOD(H), .BLANK_CYCLES(B), .PERIODS(P), .COUNT_WIDTH(CW)) dut (
    .clock_50_mhz(clk), .reset(rst), .run(run), .pulse_in(pulse),
    .light_source_pin(light), .busy(busy), .state(st),
    .add_count(addc), .subtract_count(subc), .difference(diff),
    .blank_count(blkc), .result_valid(rv));

  acquisition_sequencer #(.HALF_PERIOD(40), .BLANK_CYCLES(0), .PERIODS(1), .COUNT_WIDTH(4)) dut_sat (
    .clock_50_mhz(clk), .reset(rst), .run(run_b), .pulse_in(pulse_b),
    .light_source_pin(light_b), .busy(busy_b), .state(st_b),
    .add_count(add_b), .subtract_count(sub_b), .difference(diff_b),
    .blank_count(blk_b), .result_valid(rv_b));

  int vecs = 0, fails = 0, cyc = 0;
  int m_pos;
  logic [CW-1:0] m_add, m_sub, m_blk, e_add, e_sub, e_blk;
  logic signed [CW:0] e_diff;
  logic e_rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sinc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1;
  endfunction

  // Window position: -1 idle, 0..WIN-1 inside half periods, WIN is the latch cycle.
  function automatic logic [1:0] exp_state();
    if (m_pos < 0) return 2'd0;
    if (m_pos == WIN) return 2'd3;
    return ((m_pos % H) < B) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic exp_light();
    return (m_pos >= 0) && (m_pos < WIN) && (((m_pos / H) % 2) == 0);
  endfunction

  task automatic model(input logic r, input logic p, input logic rs);
    e_rv = 1'b0;
    if (rs) begin
      m_pos = -1; m_add = '0; m_sub = '0; m_blk = '0;
      e_add = '0; e_sub = '0; e_blk = '0; e_diff = '0;
    end else if (m_pos < 0) begin
      if (r) m_pos = 0;
    end else if (m_pos == WIN) begin
      if (BLK_EN && p) m_blk = sinc(m_blk);
      e_add = m_add; e_sub = m_sub; e_blk = m_blk;
      e_diff = $signed({1'b0, m_add}) - $signed({1'b0, m_sub});
      m_add = '0; m_sub = '0; m_blk = '0;
      e_rv = 1'b1;
      m_pos = r ? 0 : -1;
    end else if (!r) begin
      m_pos = -1; m_add = '0; m_sub = '0; m_blk = '0;
    end else begin
      if (p) begin
        if ((m_pos % H) < B) begin
          if (BLK_EN) m_blk = sinc(m_blk);
        end else if (((m_pos / H) % 2) == 0) m_add = sinc(m_add);
        else m_sub = sinc(m_sub);
      end
      m_pos++;
    end
  endtask

  task automatic step(input logic r, input logic p, input logic rs);
    run = r; pulse = p; rst = rs;
    @(posedge clk);
    model(r, p, rs);
    cyc++;
    #1;
    chk("state", st, exp_state());
    chk("light", light, exp_light());
    chk("busy", busy, m_pos >= 0);
    chk("result_valid", rv, e_rv);
    chk("add_count", addc, e_add);
    chk("subtract_count", subc, e_sub);
    chk("difference", diff, e_diff);
    chk("blank_count", blkc, e_blk);
  endtask

  // mode 0: pulse always, 1: light-on COUNT only, 2: light-off COUNT only, 3: random
  task automatic run_window(input int mode, input bit rnd_abort);
    for (int i = 0; i < WIN + 5; i++) begin
      logic p;
      logic in_cnt;
      in_cnt = (m_pos >= 0) && (m_pos < WIN) && ((m_pos % H) >= B);
      case (mode)
        0: p = 1'b1;
        1: p = in_cnt && (((m_pos / H) % 2) == 0);
        2: p = in_cnt && (((m_pos / H) % 2) == 1);
        default: p = 1'($urandom_range(0, 1));
      endcase
      if (m_pos == WIN || (rnd_abort && $urandom_range(0, 29) == 0)) begin
        step(1'b0, p, 1'b0);
        break;
      end
      step(1'b1, p, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, n;
    run = 0; pulse = 0; rst = 1; run_b = 0; pulse_b = 0;
    step(1'b0, 1'b0, 1'b1);
    chk("reset_state", st, 2'd0);
    chk("reset_light", light, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // continuous run and pulse: two back-to-back windows
    step(1'b1, 1'b1, 1'b0);
    c0 = cyc;
    for (n = 0; n < 40 && !rv; n++) step(1'b1, 1'b1, 1'b0);
    chk("rv_latency1", cyc - c0, 33);
    chk("cont_add", addc, 12);
    chk("cont_sub", subc, 12);
    chk("cont_diff", diff, 0);
    chk("cont_blank", blkc, BLK_EN ? 9 : 0);
    chk("light_after_latch", light, 1'b1);
    c1 = cyc;
    step(1'b1, 1'b1, 1'b0);
    for (n = 0; n < 40 && !rv; n++) step(1'b1, 1'b1, 1'b0);
    chk("rv_latency2", cyc - c1, 33);
    step(1'b0, 1'b1, 1'b0);
    chk("stop_idle", st, 2'd0);

    run_window(1, 1'b0);
    chk("on_add", addc, 12);
    chk("on_sub", subc, 0);
    chk("on_diff", diff, 33'sd12);
    run_window(2, 1'b0);
    chk("off_add", addc, 0);
    chk("off_sub", subc, 12);
    chk("off_diff", diff, -33'sd12);

    // abort at cycle 20 of a window
    step(1'b1, 1'b1, 1'b0);
    while (m_pos < 20) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("abort_state", st, 2'd0);
    chk("abort_light", light, 1'b0);
    chk("abort_rv", rv, 1'b0);
    chk("abort_keep_sub", subc, 12);
    chk("abort_keep_diff", diff, -33'sd12);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    run_window(0, 1'b0);
    chk("post_abort_add", addc, 12);
    chk("post_abort_sub", subc, 12);

    // randomised windows with occasional aborts and idle gaps
    for (int w = 0; w < 8; w++) begin
      run_window(3, w[0]);
      repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // reset mid-window
    repeat (11) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("mrst_state", st, 2'd0);
    chk("mrst_light", light, 1'b0);
    chk("mrst_add", addc, 0);
    chk("mrst_sub", subc, 0);
    chk("mrst_diff", diff, 0);
    chk("mrst_rv", rv, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // saturation on a narrow-count instance
    run_b = 1; pulse_b = 1;
    for (n = 0; n < 100 && !rv_b; n++) step(1'b0, 1'b0, 1'b0);
    chk("sat_seen", rv_b, 1'b1);
    chk("sat_add", add_b, 4'd15);
    chk("sat_sub", sub_b, 4'd15);
    chk("sat_diff", diff_b, 5'd0);
    run_b = 0; pulse_b = 0;
    step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
